// File: rtl/reg8_op_arbiter_if.sv
// Request/ack and datapath-control bundle for the reg8 operation arbiter.
// master = requester side, slave = arbiter.
interface reg8_op_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             req0;
  logic [1:0]       op0;
  logic [3:0]       arg0;
  logic             ack0;
  logic             req1;
  logic [1:0]       op1;
  logic [3:0]       arg1;
  logic             ack1;
  logic             A;
  logic             B;
  logic             C;
  logic [3:0]       D;
  logic             busy;
  logic             gnt_id;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output req0, op0, arg0, req1, op1, arg1,
    input  ack0, ack1, A, B, C, D, busy, gnt_id, done_cnt
  );

  modport slave (
    input  req0, op0, arg0, req1, op1, arg1,
    output ack0, ack1, A, B, C, D, busy, gnt_id, done_cnt
  );
endinterface

// File: rtl/reg8_op_arbiter.sv
// Round-robin arbiter sharing the 8-bit register datapath between two
// requesters. Drives A/B/C/D for HOLD_CYCLES per operation, then acks.
// Every output comes straight from a flop; the grant edge already loads
// the strobes so they are high from the sampling edge onward.
module reg8_op_arbiter #(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               rstN,
  reg8_op_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       arg_q, arg_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       abc_q, abc_d;
  logic [3:0]       d_q, d_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             win;

  // opcode -> {A,B,C}
  function automatic logic [2:0] strobes(input logic [1:0] op);
    case (op)
      2'b00:   strobes = 3'b100;
      2'b01:   strobes = 3'b010;
      2'b10:   strobes = 3'b001;
      default: strobes = 3'b111;
    endcase
  endfunction

  // Next-state and next-output logic; ties go to the requester not served last
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    op_d    = op_q;
    arg_d   = arg_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    abc_d   = 3'b000;
    d_d     = d_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    busy_d  = busy_q;
    win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.req0 || bus.req1) begin
          state_d = DRIVE;
          hold_d  = HOLD_LD;
          gnt_d   = win;
          op_d    = win ? bus.op1  : bus.op0;
          arg_d   = win ? bus.arg1 : bus.arg0;
          abc_d   = strobes(op_d);
          d_d     = arg_d;
          busy_d  = 1'b1;
        end
      end
      DRIVE: begin
        busy_d = 1'b1;
        d_d    = arg_q;
        if (hold_q == 4'd0) begin
          // Last drive cycle: drop strobes and ack on the way into DONE
          state_d = DONE;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          cnt_d   = cnt_q + 1'b1;
          last_d  = gnt_q;
        end else begin
          hold_d = hold_q - 4'd1;
          abc_d  = strobes(op_q);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= IDLE;
      hold_q  <= 4'd0;
      op_q    <= 2'd0;
      arg_q   <= 4'd0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      abc_q   <= 3'b000;
      d_q     <= 4'd0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      d_q     <= d_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.A        = abc_q[2];
  assign bus.B        = abc_q[1];
  assign bus.C        = abc_q[0];
  assign bus.D        = d_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.busy     = busy_q;
  assign bus.gnt_id   = gnt_q;
  assign bus.done_cnt = cnt_q;

endmodule
